branch_predictor_bht: RTL and testbench

Parametrised dynamic branch predictor for the pipelined core. It combines a branch history table of 2-bit saturating counters with a tagged branch target buffer, and selects bimodal or gshare indexing through a parameter. The IF stage uses its combinational lookup port. The EX stage uses its update port once a branch resolves, and gets a same-cycle mispredict flag to drive the pipeline flush and PC redirect. It also keeps saturating branch and mispredict statistics counters.

---
 rtl/branch_predictor_bht.sv | 157 +++++++++++++++
 tb/tb_branch_predictor_bht.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_bht.sv
// Dynamic branch predictor: 2-bit saturating BHT plus tagged BTB, bimodal or
// gshare indexed, with a combinational fetch-side lookup, an EX-side update
// port, a same-cycle mispredict flag and saturating statistics counters.
//
// Update port protocol: there is no valid/ready pair. i_upd_valid qualifies
// the i_upd_* bundle for exactly the cycle it is high. The predictor always
// accepts it, so at most one update lands per rising edge and nothing stalls.
module branch_predictor_bht #(
  parameter int ADDR_WIDTH = 32,
  parameter int INDEX_BITS = 6,
  parameter int GHR_BITS   = 0,
  parameter int TAG_BITS   = 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  // IF-stage lookup
  input  logic [ADDR_WIDTH-1:0]      i_lookup_pc,
  output logic                       o_pred_taken,
  output logic [ADDR_WIDTH-1:0]      o_pred_target,
  output logic                       o_btb_hit,
  output logic [INDEX_BITS-1:0]      o_pred_index,
  // EX-stage update
  input  logic                       i_upd_valid,
  input  logic [ADDR_WIDTH-1:0]      i_upd_pc,
  input  logic [INDEX_BITS-1:0]      i_upd_index,
  input  logic                       i_upd_taken,
  input  logic [ADDR_WIDTH-1:0]      i_upd_target,
  input  logic                       i_upd_pred_taken,
  input  logic [ADDR_WIDTH-1:0]      i_upd_pred_target,
  output logic                       o_mispredict,
  // status
  output logic [((GHR_BITS > 0) ? GHR_BITS : 1)-1:0] o_ghr,
  output logic [CNT_WIDTH-1:0]       o_branch_count,
  output logic [CNT_WIDTH-1:0]       o_mispredict_count
);

  localparam int DEPTH = 1 << INDEX_BITS;
  localparam int GW    = (GHR_BITS > 0) ? GHR_BITS : 1;

  // Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
  localparam logic [1:0] CNT_STRONG_NT = 2'b00;
  localparam logic [1:0] CNT_WEAK_NT   = 2'b01;
  localparam logic [1:0] CNT_STRONG_T  = 2'b11;

  // Stored state
  logic [1:0]            bht_q        [DEPTH];
  logic                  btb_valid_q  [DEPTH];
  logic [TAG_BITS-1:0]   btb_tag_q    [DEPTH];
  logic [ADDR_WIDTH-1:0] btb_target_q [DEPTH];
  logic [GW-1:0]         ghr_q, ghr_d;
  logic [CNT_WIDTH-1:0]  branch_cnt_q, branch_cnt_d;
  logic [CNT_WIDTH-1:0]  misp_cnt_q, misp_cnt_d;

  // Lookup-side decode
  logic [INDEX_BITS-1:0] lk_btb_idx;
  logic [INDEX_BITS-1:0] lk_bht_idx;
  logic [INDEX_BITS-1:0] ghr_ext;
  logic [TAG_BITS-1:0]   lk_tag;
  logic                  lk_hit;

  // Update-side decode
  logic [INDEX_BITS-1:0] upd_btb_idx;
  logic [TAG_BITS-1:0]   upd_tag;
  logic [1:0]            bht_wr_d;

  // Only the index/tag fields of the PCs are consumed.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{i_lookup_pc, i_upd_pc};

  // History folded into the index is zero-extended; bimodal builds use none.
  generate
    if (GHR_BITS > 0) begin : g_ghr_ext
      assign ghr_ext = INDEX_BITS'(ghr_q);
    end else begin : g_no_ghr_ext
      assign ghr_ext = '0;
    end
  endgenerate

  assign lk_btb_idx = i_lookup_pc[INDEX_BITS+1:2];
  assign lk_tag     = i_lookup_pc[INDEX_BITS+2 +: TAG_BITS];
  // While rst is high the history is treated as zero so the index is bimodal.
  assign lk_bht_idx = lk_btb_idx ^ (rst ? '0 : ghr_ext);

  // Lookup is a pure read of registered state: an update in the same cycle
  // is not bypassed, so fetch sees the pre-update entry.
  assign lk_hit        = !rst && btb_valid_q[lk_btb_idx] && (btb_tag_q[lk_btb_idx] == lk_tag);
  assign o_btb_hit     = lk_hit;
  assign o_pred_target = lk_hit ? btb_target_q[lk_btb_idx] : '0;
  assign o_pred_taken  = lk_hit && bht_q[lk_bht_idx][1];
  assign o_pred_index  = lk_bht_idx;

  assign o_ghr              = rst ? '0 : ghr_q;
  assign o_branch_count     = rst ? '0 : branch_cnt_q;
  assign o_mispredict_count = rst ? '0 : misp_cnt_q;

  // Flush request is purely a function of the update bundle, independent of rst.
  assign o_mispredict = i_upd_valid &&
                        ((i_upd_taken != i_upd_pred_taken) ||
                         (i_upd_taken && (i_upd_target != i_upd_pred_target)));

  assign upd_btb_idx = i_upd_pc[INDEX_BITS+1:2];
  assign upd_tag     = i_upd_pc[INDEX_BITS+2 +: TAG_BITS];

  // Next-state for the addressed BHT counter, history and statistics.
  always_comb begin
    bht_wr_d     = bht_q[i_upd_index];
    ghr_d        = ghr_q;
    branch_cnt_d = branch_cnt_q;
    misp_cnt_d   = misp_cnt_q;
    if (i_upd_valid) begin
      if (i_upd_taken && (bht_q[i_upd_index] != CNT_STRONG_T)) begin
        bht_wr_d = bht_q[i_upd_index] + 2'd1;
      end else if (!i_upd_taken && (bht_q[i_upd_index] != CNT_STRONG_NT)) begin
        bht_wr_d = bht_q[i_upd_index] - 2'd1;
      end
      if (GHR_BITS > 0) begin
        ghr_d = GW'({ghr_q, i_upd_taken});
      end
      if (branch_cnt_q != '1) begin
        branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
      end
    end
    if (o_mispredict && (misp_cnt_q != '1)) begin
      misp_cnt_d = misp_cnt_q + CNT_WIDTH'(1);
    end
  end

  // State registers; reset wins over a same-cycle update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        bht_q[i]        <= CNT_WEAK_NT;
        btb_valid_q[i]  <= 1'b0;
        btb_tag_q[i]    <= '0;
        btb_target_q[i] <= '0;
      end
      ghr_q        <= '0;
      branch_cnt_q <= '0;
      misp_cnt_q   <= '0;
    end else begin
      if (i_upd_valid) begin
        bht_q[i_upd_index] <= bht_wr_d;
        // Not-taken outcomes carry no useful target, so the BTB is left alone.
        if (i_upd_taken) begin
          btb_valid_q[upd_btb_idx]  <= 1'b1;
          btb_tag_q[upd_btb_idx]    <= upd_tag;
          btb_target_q[upd_btb_idx] <= i_upd_target;
        end
      end
      ghr_q        <= ghr_d;
      branch_cnt_q <= branch_cnt_d;
      misp_cnt_q   <= misp_cnt_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed bench for branch_predictor_bht: a bimodal instance and a gshare
// instance (GHR_BITS=4) share one stimulus stream.
module tb_branch_predictor_bht;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stimulus signals ----------------
  logic [31:0] lookup_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [5:0]  upd_index;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;

  // bimodal instance outputs
  logic        b_pred_taken, b_btb_hit, b_misp;
  logic [31:0] b_pred_target;
  logic [5:0]  b_pred_index;
  logic [0:0]  b_ghr;
  logic [31:0] b_branch_count, b_misp_count;

  // gshare instance outputs
  logic        g_pred_taken, g_btb_hit, g_misp;
  logic [31:0] g_pred_target;
  logic [5:0]  g_pred_index;
  logic [3:0]  g_ghr;
  logic [31:0] g_branch_count, g_misp_count;

  branch_predictor_bht dut (
    .clk               (clk),
    .rst               (rst),
    .i_lookup_pc       (lookup_pc),
    .o_pred_taken      (b_pred_taken),
    .o_pred_target     (b_pred_target),
    .o_btb_hit         (b_btb_hit),
    .o_pred_index      (b_pred_index),
    .i_upd_valid       (upd_valid),
    .i_upd_pc          (upd_pc),
    .i_upd_index       (upd_index),
    .i_upd_taken       (upd_taken),
    .i_upd_target      (upd_target),
    .i_upd_pred_taken  (upd_pred_taken),
    .i_upd_pred_target (upd_pred_target),
    .o_mispredict      (b_misp),
    .o_ghr             (b_ghr),
    .o_branch_count    (b_branch_count),
    .o_mispredict_count(b_misp_count)
  );

  branch_predictor_bht #(.GHR_BITS(4)) dut_g (
    .clk               (clk),
    .rst               (rst),
    .i_lookup_pc       (lookup_pc),
    .o_pred_taken      (g_pred_taken),
    .o_pred_target     (g_pred_target),
    .o_btb_hit         (g_btb_hit),
    .o_pred_index      (g_pred_index),
    .i_upd_valid       (upd_valid),
    .i_upd_pc          (upd_pc),
    .i_upd_index       (upd_index),
    .i_upd_taken       (upd_taken),
    .i_upd_target      (upd_target),
    .i_upd_pred_taken  (upd_pred_taken),
    .i_upd_pred_target (upd_pred_target),
    .o_mispredict      (g_misp),
    .o_ghr             (g_ghr),
    .o_branch_count    (g_branch_count),
    .o_mispredict_count(g_misp_count)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [0:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    upd_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic [5:0] idx, input logic tk,
                         input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    upd_valid       = 1'b1;
    upd_pc          = pc;
    upd_index       = idx;
    upd_taken       = tk;
    upd_target      = tgt;
    upd_pred_taken  = ptk;
    upd_pred_target = ptgt;
  endtask

  // One update cycle; the expected flush flag goes through the queue.
  task automatic upd(input logic [31:0] pc, input logic [5:0] idx, input logic tk,
                     input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
                     input logic exp_m);
    set_upd(pc, idx, tk, tgt, ptk, ptgt);
    exp_q.push_back(exp_m);
    #1;
    check("mispredict", {31'd0, b_misp}, {31'd0, exp_q.pop_front()});
    tick();
    upd_valid = 1'b0;
    #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b1;
    lookup_pc = 32'h100;
    set_upd(32'h0, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    upd_valid = 1'b0;
    tick();
    tick();

    // Reset state (still in reset, then after release)
    check("rst_hit_during", {31'd0, b_btb_hit}, 32'd0);
    check("rst_gghr_during", {28'd0, g_ghr}, 32'd0);
    rst = 1'b0;
    #1;
    check("rst_hit", {31'd0, b_btb_hit}, 32'd0);
    check("rst_taken", {31'd0, b_pred_taken}, 32'd0);
    check("rst_target", b_pred_target, 32'd0);
    check("rst_index", {26'd0, b_pred_index}, 32'h00);
    check("rst_bcount", b_branch_count, 32'd0);
    check("rst_mcount", b_misp_count, 32'd0);

    // Bimodal training at pc 0x100 (index 0, tag 0x01)
    upd(32'h100, 6'd0, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1);    // 01 -> 10
    check("train1_taken", {31'd0, b_pred_taken}, 32'd1);
    check("train1_hit", {31'd0, b_btb_hit}, 32'd1);
    check("train1_target", b_pred_target, 32'h200);
    upd(32'h100, 6'd0, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0);  // 10 -> 11
    upd(32'h100, 6'd0, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0);  // 11 sat
    upd(32'h100, 6'd0, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0);  // 11 sat
    upd(32'h100, 6'd0, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0);  // 11 sat
    check("sat_taken", {31'd0, b_pred_taken}, 32'd1);
    upd(32'h100, 6'd0, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1);    // 11 -> 10
    check("nt1_taken", {31'd0, b_pred_taken}, 32'd1);
    upd(32'h100, 6'd0, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1);    // 10 -> 01
    check("nt2_taken", {31'd0, b_pred_taken}, 32'd0);
    check("nt2_hit", {31'd0, b_btb_hit}, 32'd1);
    check("nt2_target", b_pred_target, 32'h200);
    check("train_bcount", b_branch_count, 32'd7);
    check("train_mcount", b_misp_count, 32'd3);
    // Same index, different tag: no hit
    lookup_pc = 32'h200;
    #1;
    check("alias_hit", {31'd0, b_btb_hit}, 32'd0);
    check("alias_target", b_pred_target, 32'd0);
    check("alias_index", {26'd0, b_pred_index}, 32'h00);
    lookup_pc = 32'h104;
    #1;
    check("idx1_index", {26'd0, b_pred_index}, 32'h01);
    check("idx1_hit", {31'd0, b_btb_hit}, 32'd0);
    lookup_pc = 32'h100;

    // Mispredict detection from a fresh state
    do_reset();
    upd(32'h100, 6'd0, 1'b1, 32'h200, 1'b1, 32'h204, 1'b1);  // wrong target
    check("misp_mcount", b_misp_count, 32'd1);
    upd(32'h100, 6'd0, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0);  // exact match
    upd(32'h100, 6'd0, 1'b0, 32'h300, 1'b0, 32'h400, 1'b0);  // NT: targets ignored
    check("match_mcount", b_misp_count, 32'd1);
    check("match_bcount", b_branch_count, 32'd3);
    set_upd(32'h100, 6'd0, 1'b1, 32'h200, 1'b0, 32'h0);
    upd_valid = 1'b0;
    #1;
    check("novalid_misp", {31'd0, b_misp}, 32'd0);
    tick();
    check("novalid_bcount", b_branch_count, 32'd3);

    // Same-cycle lookup and update to the same entry: no bypass
    do_reset();
    lookup_pc = 32'h100;
    set_upd(32'h100, 6'd0, 1'b1, 32'h200, 1'b0, 32'h0);
    #1;
    check("coll_taken_now", {31'd0, b_pred_taken}, 32'd0);
    check("coll_hit_now", {31'd0, b_btb_hit}, 32'd0);
    tick();
    upd_valid = 1'b0;
    #1;
    check("coll_taken_next", {31'd0, b_pred_taken}, 32'd1);
    check("coll_hit_next", {31'd0, b_btb_hit}, 32'd1);

    // Reset together with a taken update: update dropped
    set_upd(32'h104, 6'd1, 1'b1, 32'h300, 1'b0, 32'h0);
    rst = 1'b1;
    #1;
    check("midrst_hit_during", {31'd0, b_btb_hit}, 32'd0);
    check("midrst_misp_during", {31'd0, b_misp}, 32'd1);
    tick();
    rst = 1'b0;
    upd_valid = 1'b0;
    #1;
    check("midrst_hit", {31'd0, b_btb_hit}, 32'd0);
    check("midrst_taken", {31'd0, b_pred_taken}, 32'd0);
    check("midrst_bcount", b_branch_count, 32'd0);
    check("midrst_mcount", b_misp_count, 32'd0);
    lookup_pc = 32'h104;
    #1;
    check("midrst_hit104", {31'd0, b_btb_hit}, 32'd0);
    lookup_pc = 32'h100;
    upd(32'h100, 6'd0, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1);    // 01 -> 10
    check("postrst_taken", {31'd0, b_pred_taken}, 32'd1);
    upd(32'h100, 6'd0, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1);    // 10 -> 01
    check("postrst_nt", {31'd0, b_pred_taken}, 32'd0);

    // Gshare history and indexing
    do_reset();
    lookup_pc = 32'h100;
    upd(32'h100, 6'd0, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0);
    upd(32'h100, 6'd0, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1);
    check("ghr_10", {28'd0, g_ghr}, 32'h2);
    upd(32'h100, 6'd0, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0);
    upd(32'h100, 6'd0, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0);
    check("ghr_1011", {28'd0, g_ghr}, 32'hB);
    check("bghr_zero", {31'd0, b_ghr}, 32'd0);
    check("g_index", {26'd0, g_pred_index}, 32'h0B);
    check("b_index", {26'd0, b_pred_index}, 32'h00);
    check("g_hit", {31'd0, g_btb_hit}, 32'd1);
    check("g_taken", {31'd0, g_pred_taken}, 32'd0);   // bht[0x0B] untouched, 01
    check("b_taken", {31'd0, b_pred_taken}, 32'd1);   // bht[0] = 11
    upd(32'h100, 6'd0, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0);
    check("ghr_shift", {28'd0, g_ghr}, 32'h7);
    check("g_index2", {26'd0, g_pred_index}, 32'h07);
    check("g_bcount", g_branch_count, 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
